breakout_game_ctrl: RTL and testbench

Game-level sequencer for the breakout datapath: owns the brick-present mask, lives counter and score, and decides when the ball may move, when it is re-served, and when the game is won or over. Sits beside the paddle/ball/brick renderer, consuming its per-frame tick and collision events and driving back enables and the brick mask that gate what is drawn.

---
 rtl/breakout_pkg.sv | 31 +++
 rtl/btn_edge.sv | 21 ++
 rtl/breakout_game_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_breakout_game_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/breakout_pkg.sv
// breakout_pkg: shared state encoding, default sizing constants and the
// popcount helper used to score simultaneous brick hits.
package breakout_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_LOST  = 3'd4,
        ST_WON   = 3'd5,
        ST_OVER  = 3'd6
    } state_e;

    localparam int DEF_NUM_BRICKS = 5;
    localparam int DEF_LIVES      = 3;

    // Widest brick vector the popcount helper accepts; callers zero-extend.
    localparam int MAX_BRICKS     = 32;

    // Number of set bits in a (zero-extended) brick vector.
    function automatic logic [5:0] popcount(input logic [MAX_BRICKS-1:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < MAX_BRICKS; i++) begin
            c = c + {5'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// btn_edge: rising-edge detector for a debounced level button. The pulse is
// combinational from the live level and the previous-level register, so a
// press in cycle N can change registered state at the end of cycle N.
module btn_edge (
    input  logic clock,
    input  logic reset,
    input  logic btn_i,
    output logic rise_o
);

    logic prev_q;

    // Remember last cycle's level; a held button produces a single pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) prev_q <= 1'b0;
        else        prev_q <= btn_i;
    end

    assign rise_o = btn_i & ~prev_q;

endmodule

// File: rtl/breakout_game_ctrl.sv
// breakout_game_ctrl: game-level sequencer for the breakout datapath.
// Owns the brick mask, lives and score, and sequences
// IDLE -> SERVE -> PLAY -> (LOST -> SERVE | WON | OVER).
// Optional feature macro: BREAKOUT_PAUSE_EN enables the PAUSE state; when it
// is undefined btnPause is accepted but has no effect.
module breakout_game_ctrl
    import breakout_pkg::*;
#(
    parameter int NUM_BRICKS   = DEF_NUM_BRICKS,
    parameter int LIVES        = DEF_LIVES,
    parameter int SCORE_W      = 8,
    parameter int SERVE_FRAMES = 60
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  frameTick,
    input  logic                  btnStart,
    input  logic                  btnPause,
    input  logic                  ballLost,
    input  logic [NUM_BRICKS-1:0] brickHit,
    output logic [NUM_BRICKS-1:0] brickMask,
    output logic                  ballEnable,
    output logic                  ballServe,
    output logic [2:0]            lives,
    output logic [SCORE_W-1:0]    score,
    output logic                  gameOver,
    output logic                  gameWon,
    output logic [2:0]            state
);

    localparam int          CNT_W      = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
    localparam logic [2:0]  LIVES_INIT = 3'(LIVES);
    localparam logic [31:0] SCORE_MAX  = (32'd1 << SCORE_W) - 32'd1;
    localparam logic [31:0] LAST_TICK  = (SERVE_FRAMES > 0) ? 32'(SERVE_FRAMES - 1) : 32'd0;

    state_e                state_q;
    logic [NUM_BRICKS-1:0] mask_q;
    logic [NUM_BRICKS-1:0] mask_d;
    logic [NUM_BRICKS-1:0] cleared;
    logic [2:0]            lives_q;
    logic [SCORE_W-1:0]    score_q;
    logic [SCORE_W-1:0]    score_d;
    logic [31:0]           score_sum;
    logic [CNT_W-1:0]      cnt_q;
    logic                  en_q;
    logic                  serve_q;
    logic                  over_q;
    logic                  won_q;
    logic                  start_rise;
    logic                  pause_rise;

    btn_edge u_start_edge (
        .clock  (clock),
        .reset  (reset),
        .btn_i  (btnStart),
        .rise_o (start_rise)
    );

    btn_edge u_pause_edge (
        .clock  (clock),
        .reset  (reset),
        .btn_i  (btnPause),
        .rise_o (pause_rise)
    );

`ifndef BREAKOUT_PAUSE_EN
    // Pause detector kept for a stable interface; its pulse goes nowhere.
    logic unused_pause;
    assign unused_pause = pause_rise;
`endif

    // Brick clearing and saturating score for this cycle's hits; only
    // bricks still present count, so repeat hits score nothing.
    always_comb begin
        cleared   = brickHit & mask_q;
        mask_d    = mask_q & ~cleared;
        score_sum = 32'(score_q) + 32'(popcount(MAX_BRICKS'(cleared)));
        if (score_sum > SCORE_MAX) score_d = '1;
        else                       score_d = score_sum[SCORE_W-1:0];
    end

    // Game sequencer; every output is a register updated together with state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            mask_q  <= '1;
            lives_q <= LIVES_INIT;
            score_q <= '0;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            serve_q <= 1'b0;
            over_q  <= 1'b0;
            won_q   <= 1'b0;
        end else begin
            serve_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    mask_q  <= '1;
                    lives_q <= LIVES_INIT;
                    score_q <= '0;
                    cnt_q   <= '0;
                    if (start_rise) begin
                        state_q <= ST_SERVE;
                        serve_q <= 1'b1;
                    end
                end
                ST_SERVE: begin
                    if (start_rise) begin
                        state_q <= ST_PLAY;
                        en_q    <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    mask_q  <= mask_d;
                    score_q <= score_d;
                    // Clearing the last brick wins even if the ball is lost
                    // in the same cycle.
                    if (mask_d == '0) begin
                        state_q <= ST_WON;
                        won_q   <= 1'b1;
                        en_q    <= 1'b0;
                    end else if (ballLost) begin
                        state_q <= ST_LOST;
                        lives_q <= lives_q - 3'd1;
                        cnt_q   <= '0;
                        en_q    <= 1'b0;
                    end
`ifdef BREAKOUT_PAUSE_EN
                    else if (pause_rise) begin
                        state_q <= ST_PAUSE;
                        en_q    <= 1'b0;
                    end
`endif
                end
`ifdef BREAKOUT_PAUSE_EN
                ST_PAUSE: begin
                    if (pause_rise) begin
                        state_q <= ST_PLAY;
                        en_q    <= 1'b1;
                    end
                end
`endif
                ST_LOST: begin
                    // Lives already decremented on the way in; zero means game over.
                    if (lives_q == 3'd0) begin
                        state_q <= ST_OVER;
                        over_q  <= 1'b1;
                    end else if (SERVE_FRAMES == 0) begin
                        state_q <= ST_SERVE;
                        serve_q <= 1'b1;
                    end else if (frameTick) begin
                        if (32'(cnt_q) == LAST_TICK) begin
                            state_q <= ST_SERVE;
                            serve_q <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                ST_WON, ST_OVER: begin
                    // Mask and score stay up for display until the player restarts.
                    if (start_rise) begin
                        state_q <= ST_IDLE;
                        won_q   <= 1'b0;
                        over_q  <= 1'b0;
                        mask_q  <= '1;
                        lives_q <= LIVES_INIT;
                        score_q <= '0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    en_q    <= 1'b0;
                    won_q   <= 1'b0;
                    over_q  <= 1'b0;
                end
            endcase
        end
    end

    assign brickMask  = mask_q;
    assign ballEnable = en_q;
    assign ballServe  = serve_q;
    assign lives      = lives_q;
    assign score      = score_q;
    assign gameOver   = over_q;
    assign gameWon    = won_q;
    assign state      = state_q;

endmodule

// File: tb/tb_breakout_game_ctrl.sv
// Bench for breakout_game_ctrl: two instances (SCORE_W 8 and 2) share the
// stimulus; a game-rule model is compared every cycle, with literal pins on
// the test-plan scenarios followed by a randomized phase.
module tb_breakout_game_ctrl;

`ifdef BREAKOUT_PAUSE_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif
    localparam int SF = 2;

    logic       clock = 1'b0;
    logic       rst_n = 1'b0;
    logic       frameTick = 1'b0, btnStart = 1'b0, btnPause = 1'b0, ballLost = 1'b0;
    logic [4:0] brickHit = '0;

    logic [4:0] mask_a, mask_b;
    logic       en_a, en_b, srv_a, srv_b, over_a, over_b, won_a, won_b;
    logic [2:0] lives_a, lives_b, st_a, st_b;
    logic [7:0] score_a;
    logic [1:0] score_b;

    breakout_game_ctrl #(.NUM_BRICKS(5), .LIVES(3), .SCORE_W(8), .SERVE_FRAMES(SF)) dut (
        .clock(clock), .reset(rst_n), .frameTick(frameTick), .btnStart(btnStart),
        .btnPause(btnPause), .ballLost(ballLost), .brickHit(brickHit),
        .brickMask(mask_a), .ballEnable(en_a), .ballServe(srv_a), .lives(lives_a),
        .score(score_a), .gameOver(over_a), .gameWon(won_a), .state(st_a));

    breakout_game_ctrl #(.NUM_BRICKS(5), .LIVES(3), .SCORE_W(2), .SERVE_FRAMES(SF)) dut_s2 (
        .clock(clock), .reset(rst_n), .frameTick(frameTick), .btnStart(btnStart),
        .btnPause(btnPause), .ballLost(ballLost), .brickHit(brickHit),
        .brickMask(mask_b), .ballEnable(en_b), .ballServe(srv_b), .lives(lives_b),
        .score(score_b), .gameOver(over_b), .gameWon(won_b), .state(st_b));

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- game-rule model ----------------
    // States by their published numbers: 0 idle,1 serve,2 play,3 pause,4 lost,5 won,6 over.
    int m_st, m_mask, m_lives, m_sc8, m_sc2, m_frames;
    bit m_srv, m_pS, m_pP;

    task automatic mreset();
        m_st = 0; m_mask = 31; m_lives = 3; m_sc8 = 0; m_sc2 = 0;
        m_frames = 0; m_srv = 0; m_pS = 0; m_pP = 0;
    endtask

    task automatic mstep();
        bit se, pe;
        int nst, cl, n;
        se = btnStart && !m_pS;
        pe = btnPause && !m_pP;
        m_pS = btnStart;
        m_pP = btnPause;
        nst = m_st;
        case (m_st)
            0: if (se) nst = 1;
            1: if (se) nst = 2;
            2: begin
                cl = int'(brickHit) & m_mask;
                n  = $countones(cl);
                m_mask = m_mask & ~cl;
                m_sc8 = (m_sc8 + n > 255) ? 255 : m_sc8 + n;
                m_sc2 = (m_sc2 + n > 3) ? 3 : m_sc2 + n;
                if (m_mask == 0) nst = 5;
                else if (ballLost) begin nst = 4; m_lives--; m_frames = 0; end
                else if (PEN && pe) nst = 3;
            end
            3: if (pe) nst = 2;
            4: begin
                if (m_lives == 0) nst = 6;
                else if (frameTick) begin
                    m_frames++;
                    if (m_frames == SF) nst = 1;
                end
            end
            5, 6: if (se) begin
                nst = 0; m_mask = 31; m_lives = 3; m_sc8 = 0; m_sc2 = 0;
            end
            default: nst = 0;
        endcase
        m_srv = (nst == 1) && (m_st != 1);
        m_st  = nst;
    endtask

    always @(posedge clock) if (rst_n) mstep();

    // Every-cycle comparison of both instances against the model.
    always @(negedge clock) begin
        if (cmp_en && rst_n) begin
            chk("state",     32'(st_a),    32'(m_st));
            chk("mask",      32'(mask_a),  32'(m_mask));
            chk("lives",     32'(lives_a), 32'(m_lives));
            chk("score",     32'(score_a), 32'(m_sc8));
            chk("ballEn",    32'(en_a),    32'(m_st == 2));
            chk("ballServe", 32'(srv_a),   32'(m_srv));
            chk("gameOver",  32'(over_a),  32'(m_st == 6));
            chk("gameWon",   32'(won_a),   32'(m_st == 5));
            chk("s2 state",  32'(st_b),    32'(m_st));
            chk("s2 score",  32'(score_b), 32'(m_sc2));
        end
    end

    // Apply inputs at a falling edge, return at the next falling edge.
    task automatic drive(input bit s, input bit p, input bit t, input bit l, input logic [4:0] h);
        btnStart = s; btnPause = p; frameTick = t; ballLost = l; brickHit = h;
        @(negedge clock);
    endtask

    task automatic press_start();
        drive(1, 0, 0, 0, 5'd0);
        drive(0, 0, 0, 0, 5'd0);
    endtask

    initial begin
        mreset();
        repeat (2) @(negedge clock);
        chk("rst state", 32'(st_a), 0);
        chk("rst mask",  32'(mask_a), 31);
        chk("rst lives", 32'(lives_a), 3);
        chk("rst score", 32'(score_a), 0);
        chk("rst flags", {28'd0, en_a, srv_a, over_a, won_a}, 0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // start -> SERVE with one-cycle serve pulse -> PLAY
        drive(1, 0, 0, 0, 5'd0);
        chk("serve state", 32'(st_a), 1);
        chk("serve pulse", 32'(srv_a), 1);
        drive(0, 0, 0, 0, 5'd0);
        chk("serve pulse end", 32'(srv_a), 0);
        drive(1, 0, 0, 0, 5'd0);
        chk("play state", 32'(st_a), 2);
        chk("play en", 32'(en_a), 1);
        drive(0, 0, 0, 0, 5'd0);

        // hits, repeat hit unscored, saturation on SCORE_W=2, last brick + lost
        drive(0, 0, 0, 0, 5'b00101);
        chk("hit1 mask", 32'(mask_a), 32'b11010);
        chk("hit1 score", 32'(score_a), 2);
        drive(0, 0, 0, 0, 5'b00100);
        chk("rehit score", 32'(score_a), 2);
        drive(0, 0, 0, 0, 5'b01010);
        chk("hit3 mask", 32'(mask_a), 32'b10000);
        chk("s2 sat", 32'(score_b), 3);
        drive(0, 0, 0, 1, 5'b10000);
        chk("won state", 32'(st_a), 5);
        chk("won flag", 32'(won_a), 1);
        chk("won lives", 32'(lives_a), 3);
        chk("won score", 32'(score_a), 5);
        chk("won s2", 32'(score_b), 3);

        // back to IDLE, then lose all three lives
        press_start();
        chk("idle again", 32'(st_a), 0);
        press_start();
        press_start();
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 0, 1, 5'd0);
            chk("lost lives", 32'(lives_a), 32'(2 - k));
            drive(0, 0, 1, 0, 5'd0);
            chk("lost wait", 32'(st_a), 4);
            drive(0, 0, 0, 0, 5'd0);
            drive(0, 0, 1, 0, 5'd0);
            chk("reserve state", 32'(st_a), 1);
            chk("reserve pulse", 32'(srv_a), 1);
            press_start();
        end
        drive(0, 0, 0, 1, 5'd0);
        chk("last life", 32'(lives_a), 0);
        drive(0, 0, 0, 0, 5'd0);
        chk("over state", 32'(st_a), 6);
        chk("over flag", 32'(over_a), 1);
        press_start();
        chk("restart lives", 32'(lives_a), 3);

        // pause behaviour depends on build
        press_start();
        press_start();
        drive(0, 1, 0, 0, 5'd0);
        chk("pause state", 32'(st_a), PEN ? 32'd3 : 32'd2);
        drive(0, 1, 0, 0, 5'b00001);
        chk("pause mask", 32'(mask_a), PEN ? 32'd31 : 32'd30);
        chk("pause en", 32'(en_a), PEN ? 32'd0 : 32'd1);
        drive(0, 0, 0, 0, 5'd0);
        drive(0, 1, 0, 0, 5'd0);
        chk("unpause state", 32'(st_a), 2);
        drive(0, 0, 0, 0, 5'd0);

        // randomized play, with one asynchronous reset mid-run
        for (int c = 0; c < 2500; c++) begin
            if (c == 1200) begin
                #2 rst_n = 1'b0;
                mreset();
                #1 chk("midrst state", 32'(st_a), 0);
                chk("midrst mask", 32'(mask_a), 31);
                @(negedge clock);
                rst_n = 1'b1;
            end
            drive(($urandom % 8 == 0) ? ~btnStart : btnStart,
                  ($urandom % 12 == 0) ? ~btnPause : btnPause,
                  ($urandom % 4 == 0),
                  ($urandom % 25 == 0),
                  ($urandom % 5 == 0) ? 5'($urandom) : 5'd0);
        end

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
